// File: rtl/gpr_file.sv
// Parametrised register file: hardwired zero register, sticky overflow flag with a saturating
// event counter, and a per-register load scoreboard. Optional write-first forwarding: GPR_BYPASS_EN.
module gpr_file #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int OVF_REG = 30,
  parameter int OVF_BIT = 0,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    rA,
  input  logic [ADDR_W-1:0]    rB,
  output logic [DATA_W-1:0]    busA,
  output logic [DATA_W-1:0]    busB,
  input  logic [ADDR_W-1:0]    rW,
  input  logic [DATA_W-1:0]    busW,
  input  logic                 regWr,
  input  logic [1:0]           regDst,
  input  logic                 ld_issue,
  input  logic [ADDR_W-1:0]    ld_rd,
  output logic                 stallA,
  output logic                 stallB,
  output logic [CNT_W-1:0]     ovf_cnt,
  output logic [2**ADDR_W-1:0] busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_reg, busy_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              wr_normal, ovf_event;

  assign wr_normal = regWr && (regDst != 2'b11) && (rW != '0);
  assign ovf_event = regWr && (regDst == 2'b11);

  // Register 0 is only ever written by reset, so it reads back as zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr_normal) regs[rW] <= busW;
      if (ovf_event && (OVF_REG != 0)) regs[OVF_REG][OVF_BIT] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (ovf_event && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Set is applied after clear so a new load on the written register stays outstanding.
  always_comb begin
    busy_next = busy_reg;
    if (wr_normal) busy_next[rW] = 1'b0;
    if (ld_issue)  busy_next[ld_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) busy_reg <= '0;
    else      busy_reg <= busy_next;
  end

  assign busy    = busy_reg;
  assign ovf_cnt = cnt_reg;

`ifdef GPR_BYPASS_EN
  logic fwd_a, fwd_b;
  assign fwd_a  = wr_normal && (rW == rA);
  assign fwd_b  = wr_normal && (rW == rB);
  assign busA   = fwd_a ? busW : regs[rA];
  assign busB   = fwd_b ? busW : regs[rB];
  assign stallA = busy_reg[rA] && !fwd_a;
  assign stallB = busy_reg[rB] && !fwd_b;
`else
  assign busA   = regs[rA];
  assign busB   = regs[rB];
  assign stallA = busy_reg[rA];
  assign stallB = busy_reg[rB];
`endif

endmodule

// File: doc/gpr_file.md
Name: gpr_file

Overview:
Parametrised general-purpose register file, successor to the fixed 32x32 GPR.
- Configurable data width and depth.
- Hardwired zero register.
- Overflow-write suppression with a sticky overflow flag and a saturating overflow event counter.
- Per-register load scoreboard with read-stall outputs.
Sits between decode (read ports, scoreboard set) and writeback (write port, overflow signalling) in the single-cycle/multi-cycle datapath.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
OVF_REG, 30, index of register holding the overflow flag
OVF_BIT, 0, bit position of the overflow flag inside OVF_REG
CNT_W, 8, width of saturating overflow event counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-low reset, sampled on rising clk
rA  input  ADDR_W  read address port A
rB  input  ADDR_W  read address port B
busA  output  DATA_W  read data port A
busB  output  DATA_W  read data port B
rW  input  ADDR_W  write address
busW  input  DATA_W  write data
regWr  input  1  write request
regDst  input  2  destination select from control; 2'b11 = arithmetic overflow, write must be suppressed
ld_issue  input  1  load issued; mark ld_rd pending
ld_rd  input  ADDR_W  destination register of issued load
stallA  output  1  rA refers to a pending load
stallB  output  1  rB refers to a pending load
ovf_cnt  output  CNT_W  number of overflow events since reset, saturating
busy  output  2**ADDR_W  scoreboard vector, bit i = register i pending

Behaviour:
- Reset (rst==0 at rising clk): all registers = 0, busy = 0, ovf_cnt = 0. Reset overrides every other input in that cycle, including mid-operation writes and load issues.
- Normal write: regWr==1 && regDst!=2'b11 && rW!=0 -> regs[rW] <= busW at the clock edge. Writes to register 0 are ignored; regs[0] always reads 0.
- Overflow event: regWr==1 && regDst==2'b11.
  - No write to rW.
  - regs[OVF_REG][OVF_BIT] <= 1; other bits of OVF_REG unchanged.
  - ovf_cnt <= ovf_cnt+1, holding at all-ones (no wrap).
- regWr==0: no register change of any kind. Unlike the previous GPR, the flag is not set on idle cycles.
- Overflow flag is sticky. It is cleared only by reset or by a normal write to OVF_REG carrying 0 in OVF_BIT.
- Reads are combinational, zero latency: busA = regs[rA], busB = regs[rB]. Address 0 always returns 0.
- Scoreboard:
  - ld_issue==1 && ld_rd!=0 sets busy[ld_rd].
  - A normal write to rW clears busy[rW].
  - Same-cycle set and clear of the same register: the set wins (new load outstanding).
  - An overflow event never clears busy.
  - busy[0] is permanently 0.
- Stall outputs are combinational: stallA = busy[rA], except it is forced to 0 when a same-cycle normal write targets rA (only when bypass is compiled in). stallB likewise.
- Address width is exact; no out-of-range addresses exist.

Optional Feature:
Macro GPR_BYPASS_EN.
- Defined: write-first forwarding. When regWr==1, regDst!=2'b11, rW!=0 and rW==rA, busA = busW in the same cycle; same rule for busB. stallA/stallB are suppressed for the forwarded register.
- Undefined: reads return the pre-edge register contents. Stalls reflect busy only; the written value is visible from the next cycle.

Test Plan:
- Reset with rst=0 for 2 cycles, then read all addresses -> every busA/busB = 0, busy = 0, ovf_cnt = 0.
- Write 0xDEADBEEF to r5, then r0 <- 0x1234 -> busA(rA=5) = 0xDEADBEEF next cycle; busB(rB=0) = 0.
- regWr=1, regDst=2'b11, rW=7, busW=0xFFFF -> r7 unchanged (0); r30 bit0 = 1; ovf_cnt = 1. An idle cycle with regWr=0 afterwards leaves ovf_cnt = 1. With CNT_W=2, five overflow events give ovf_cnt = 3.
- ld_issue with ld_rd=9, then rA=9 -> stallA = 1. A write to r9 clears it next cycle. Same cycle ld_issue on r9 plus write to r9 -> busy[9] stays 1.
- GPR_BYPASS_EN defined: write r3 <- 0xA5A5A5A5 with rA=3 in the same cycle -> busA = 0xA5A5A5A5 that cycle. Undefined: busA = old r3 value.
- Mid-operation reset: write to r4 and ld_issue on r4 in the same cycle as rst=0 -> r4 = 0, busy[4] = 0 after the edge.
